mux_scan_serializer: RTL and testbench
======================================

Name: mux_scan_serializer

Overview:
- Sequencer wrapped around a 16:1 bit multiplexer; sits directly upstream and downstream of it.
- Accepts a 16-bit word over a valid/ready handshake and drives the word onto the mux data inputs.
- Steps the 4-bit mux select through all 16 channels and registers each returned mux output bit.
- Emits the bits as a backpressured serial stream with a last-bit flag.

Parameters:
- MSB_FIRST, 1, 1: select order 15→0; 0: select order 0→15.
- WIDTH, 16, word width; fixed at 16, must equal the mux input count.
- SEL_W, 4, select width; fixed at 4 (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_word  input  16  parallel word to serialize
- in_valid  input  1  in_word valid
- in_ready  output  1  block can accept a word
- mux_data  output  16  registered word driven to mux data inputs
- mux_sel  output  4  select driven to mux
- mux_out  input  1  mux output (combinational return from mux)
- ser_bit  output  1  serial data bit
- ser_valid  output  1  ser_bit valid
- ser_last  output  1  ser_bit is final bit of the word
- ser_ready  input  1  downstream accepts ser_bit
- busy  output  1  word in progress

Behaviour:
Reset:
- Asynchronous, active-high.
- Clears state to IDLE, word register 0, counter cnt 0, and ser_bit/ser_valid/ser_last to 0.
- Reset values: in_ready=1, busy=0, mux_sel=(MSB_FIRST?15:0).
- Reset mid-word discards the word; no partial-word flag is raised.

Select:
- mux_sel = MSB_FIRST ? (15-cnt) : cnt, combinational from the 4-bit counter cnt.
- mux_data = word register.

States:
- IDLE
  - in_ready=1, busy=0.
  - On in_valid&&in_ready: capture in_word, set cnt=0, go to SCAN.
- SCAN
  - in_ready=0, busy=1.
  - Capture slot is open when !ser_valid || ser_ready.
  - Each cycle with an open slot: ser_bit<=mux_out, ser_valid<=1, ser_last<=(cnt==15).
    - If cnt<15: cnt<=cnt+1.
    - If cnt==15: go to DRAIN (cnt wraps to 0).
  - Slot closed (ser_valid&&!ser_ready): hold ser_bit, ser_last, cnt, and mux_sel stable.
- DRAIN
  - busy=1, in_ready=0.
  - When ser_ready: ser_valid<=0, ser_last<=0, go to IDLE.

Output handshake:
- A bit transfers on ser_valid&&ser_ready.
- ser_bit/ser_last never change while ser_valid&&!ser_ready.

Latency and throughput:
- Word accepted at edge k → first ser_valid after edge k+1.
- With ser_ready held at 1, bits appear on 16 consecutive cycles (edges k+1..k+16).
- ser_last is high with the 16th bit; in_ready returns after edge k+17.
- Throughput: 18 cycles per word with ser_ready=1.

Boundaries:
- in_valid while in_ready=0 is ignored; in_word changes mid-word have no effect.
- ser_ready low for any length causes no loss or duplication of bits.
- The mux path is combinational: mux_out must settle within one clk period of mux_sel/mux_data.

Test Plan:
- MSB_FIRST=1, in_word=0xA5C3, ser_ready=1 → ser_bit sequence 1010_0101_1100_0011 on 16 consecutive cycles; ser_last only on the 16th bit; in_ready high again 17 cycles after acceptance.
- MSB_FIRST=0, in_word=0x0001 → first bit 1, remaining 15 bits 0; mux_sel sequence 0,1,...,15.
- Backpressure: 0xFFFE with ser_ready low for 5 cycles at bit 3 (MSB_FIRST=1) → ser_bit, ser_last, and mux_sel stable during the stall; 16 transfers total, none duplicated.
- Back-to-back: in_valid held high with 0x1234 then 0x8000 → second word accepted only after 0x1234's ser_last transfers; no bit interleaving.
- Reset asserted asynchronously after bit 7 of 0xFFFF → outputs immediately at reset values; after release, new word 0x0F0F serializes cleanly from bit 0.
- Ignored input: in_word changed to 0x0000 mid-word while in_valid=1 → original word's bits unaffected.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - sequencer that scans a word through an external 16:1 mux into a serial stream
// One word is held on mux_data while the select walks every channel; returned bits leave on a ready/valid stream.

module mux_scan_serializer #(
   parameter bit MSB_FIRST = 1'b1,
   parameter int WIDTH     = 16,
   parameter int SEL_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] mux_data,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [SEL_W-1:0] CNT_MAX = SEL_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [SEL_W-1:0] cnt_q, cnt_d;
   logic             ser_bit_q, ser_bit_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_last_q, ser_last_d;
   logic             slot_open;

   // A new bit may be captured only when the output register is empty or being consumed.
   assign slot_open = !ser_valid_q || ser_ready;

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      cnt_d       = cnt_q;
      ser_bit_d   = ser_bit_q;
      ser_valid_d = ser_valid_q;
      ser_last_d  = ser_last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = in_word;
               cnt_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (slot_open) begin
               ser_bit_d   = mux_out;
               ser_valid_d = 1'b1;
               ser_last_d  = (cnt_q == CNT_MAX);
               if (cnt_q == CNT_MAX) begin
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (ser_ready) begin
               ser_valid_d = 1'b0;
               ser_last_d  = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= '0;
         cnt_q       <= '0;
         ser_bit_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         ser_bit_q   <= ser_bit_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign mux_data  = word_q;
   assign mux_sel   = MSB_FIRST ? (CNT_MAX - cnt_q) : cnt_q;
   assign ser_bit   = ser_bit_q;
   assign ser_valid = ser_valid_q;
   assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - directed bench for mux_scan_serializer in both scan orders
// Each instance is looped back through a behavioural 16:1 mux.

module tb_mux_scan_serializer;

   logic        clk;
   logic        rst;

   logic [15:0] in_word;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mux_data;
   logic [3:0]  mux_sel;
   logic        mux_out;
   logic        ser_bit;
   logic        ser_valid;
   logic        ser_last;
   logic        ser_ready;
   logic        busy;

   logic [15:0] l_in_word;
   logic        l_in_valid;
   logic        l_in_ready;
   logic [15:0] l_mux_data;
   logic [3:0]  l_mux_sel;
   logic        l_mux_out;
   logic        l_ser_bit;
   logic        l_ser_valid;
   logic        l_ser_last;
   logic        l_ser_ready;
   logic        l_busy;

   int          total;
   int          bad;
   logic [15:0] got;
   int          nbits;
   int          nlast;
   int          lastidx;
   int          cyc;
   logic        stall_ok;

   mux_scan_serializer #(.MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
      .mux_data(mux_data), .mux_sel(mux_sel), .mux_out(mux_out),
      .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_last(ser_last),
      .ser_ready(ser_ready), .busy(busy)
   );

   mux_scan_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst),
      .in_word(l_in_word), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .mux_data(l_mux_data), .mux_sel(l_mux_sel), .mux_out(l_mux_out),
      .ser_bit(l_ser_bit), .ser_valid(l_ser_valid), .ser_last(l_ser_last),
      .ser_ready(l_ser_ready), .busy(l_busy)
   );

   assign mux_out   = mux_data[mux_sel];
   assign l_mux_out = l_mux_data[l_mux_sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the acceptance edge.
   task automatic accept(input logic [15:0] w, input logic hold, input logic [15:0] nxt);
      int g = 0;
      in_word  = w;
      in_valid = 1'b1;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("accept_wait", (g < 100), 1);
      @(negedge clk);
      if (hold) in_word = nxt;
      else in_valid = 1'b0;
   endtask

   // Sinks one word, stalling ser_ready for stall_len cycles while bit stall_at is presented.
   task automatic collect(input int stall_at, input int stall_len);
      int       stalls = 0;
      int       guard  = 0;
      logic     sb = 1'b0;
      logic     sl = 1'b0;
      logic [3:0] ss = '0;
      got = '0; nbits = 0; nlast = 0; lastidx = -1; cyc = 0; stall_ok = 1'b1;
      while (lastidx < 0 && guard < 200) begin
         if (nbits == stall_at && stalls < stall_len && ser_valid) begin
            if (stalls == 0) begin
               sb = ser_bit; sl = ser_last; ss = mux_sel;
            end else if (ser_bit !== sb || ser_last !== sl || mux_sel !== ss) begin
               stall_ok = 1'b0;
            end
            ser_ready = 1'b0;
            stalls++;
         end else begin
            ser_ready = 1'b1;
         end
         if (ser_valid && ser_ready) begin
            got = {got[14:0], ser_bit};
            if (ser_last) begin
               nlast++;
               lastidx = nbits;
            end
            nbits++;
         end
         @(negedge clk);
         guard++;
         cyc++;
      end
      ser_ready = 1'b1;
   endtask

   initial begin
      logic [15:0] lgot;
      logic        sel_ok;
      logic        last_ok;
      total = 0; bad = 0;
      rst = 1'b1;
      in_word = '0; in_valid = 1'b0; ser_ready = 1'b1;
      l_in_word = '0; l_in_valid = 1'b0; l_ser_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mux_sel_msb", mux_sel, 15);
      chk("rst_mux_sel_lsb", l_mux_sel, 0);
      chk("rst_mux_data", mux_data, 0);
      chk("rst_ser_outs", {ser_bit, ser_valid, ser_last}, 0);

      accept(16'hA5C3, 1'b0, 16'h0);
      chk("a5c3_busy", busy, 1);
      chk("a5c3_in_ready", in_ready, 0);
      chk("a5c3_mux_data", mux_data, 16'hA5C3);
      chk("a5c3_no_early_valid", ser_valid, 0);
      collect(-1, 0);
      chk("a5c3_bits", got, 16'hA5C3);
      chk("a5c3_nbits", nbits, 16);
      chk("a5c3_last_idx", lastidx, 15);
      chk("a5c3_nlast", nlast, 1);
      chk("a5c3_cycles", cyc, 17);
      chk("a5c3_in_ready_back", in_ready, 1);
      chk("a5c3_valid_low", ser_valid, 0);

      l_in_word = 16'h0001;
      l_in_valid = 1'b1;
      @(negedge clk);
      l_in_valid = 1'b0;
      lgot = '0; sel_ok = 1'b1; last_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (l_mux_sel !== 4'(i)) sel_ok = 1'b0;
         @(negedge clk);
         lgot[i] = l_ser_bit;
         if (l_ser_valid !== 1'b1 || l_ser_last !== (i == 15)) last_ok = 1'b0;
      end
      chk("lsb_sel_seq", sel_ok, 1);
      chk("lsb_bits", lgot, 16'h0001);
      chk("lsb_valid_last", last_ok, 1);
      @(negedge clk);
      chk("lsb_in_ready_back", l_in_ready, 1);

      accept(16'hFFFE, 1'b0, 16'h0);
      collect(3, 5);
      chk("bp_bits", got, 16'hFFFE);
      chk("bp_nbits", nbits, 16);
      chk("bp_nlast", nlast, 1);
      chk("bp_stable", stall_ok, 1);
      chk("bp_cycles", cyc, 22);

      accept(16'h1234, 1'b1, 16'h8000);
      collect(-1, 0);
      chk("b2b_first_bits", got, 16'h1234);
      chk("b2b_first_nbits", nbits, 16);
      chk("b2b_not_yet_taken", mux_data, 16'h1234);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_second_taken", mux_data, 16'h8000);
      chk("b2b_second_busy", busy, 1);
      collect(-1, 0);
      chk("b2b_second_bits", got, 16'h8000);
      chk("b2b_second_nbits", nbits, 16);

      accept(16'h5A5A, 1'b1, 16'h0000);
      collect(-1, 0);
      in_valid = 1'b0;
      chk("ign_bits", got, 16'h5A5A);
      chk("ign_mux_data", mux_data, 16'h5A5A);
      @(negedge clk);
      chk("ign_stays_idle", busy, 0);

      accept(16'hFFFF, 1'b0, 16'h0);
      repeat (9) @(negedge clk);
      chk("rst_mid_valid_before", ser_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_ser_outs", {ser_bit, ser_valid, ser_last}, 0);
      chk("arst_mux_sel", mux_sel, 15);
      chk("arst_mux_data", mux_data, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      accept(16'h0F0F, 1'b0, 16'h0);
      collect(-1, 0);
      chk("post_rst_bits", got, 16'h0F0F);
      chk("post_rst_nbits", nbits, 16);
      chk("post_rst_cycles", cyc, 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
